// File: rtl/uart_pkg.sv
// UART shared definitions.
// Holds the receive/transmit FSM state type, the majority-vote sample spacing and a
// 3-input majority helper. Build macro UART_RX_PARITY_EN adds the StParity state.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } uart_state_e;
`endif

  // Bits are voted from samples at mid-MajSpan, mid and mid+MajSpan of the bit period.
  localparam int unsigned MajSpan = 1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick divider.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, clears the divider
//   tick_o - one-cycle pulse every DIV cycles (high on count DIV-1)
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With DIV == 1 the counter sits at 0 == CntMax, so the tick is permanently high.
  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: 8 data bits, LSB first, 1 stop bit, oversampled with 3-sample
// majority vote per bit.
// Build macro UART_RX_PARITY_EN adds an even-parity bit between data and stop and the
// parity_err_o output; parity-failed bytes are dropped.
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset
//   uart_rxd_i   - asynchronous serial input, idle high
//   rx_clear_i   - consumer acknowledge, clears rx_ready_o and overrun_o
//   rx_ready_o   - rx_data_o holds an unacknowledged byte
//   rx_data_o    - last good received byte
//   frame_err_o  - one-cycle pulse when the stop bit votes low
//   overrun_o    - sticky: a byte completed while rx_ready_o was still set
//   parity_err_o - (parity build only) one-cycle pulse on parity mismatch
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rxd_i,
  input  logic       rx_clear_i,
  output logic       rx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       overrun_o
);

  localparam int unsigned DivRaw = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned Div    = (DivRaw > 1) ? DivRaw : 1;
  localparam int unsigned TickW  = $clog2(OVERSAMPLE);

  localparam logic [TickW-1:0] SampLo   = TickW'(OVERSAMPLE / 2 - MajSpan);
  localparam logic [TickW-1:0] SampMid  = TickW'(OVERSAMPLE / 2);
  localparam logic [TickW-1:0] SampHi   = TickW'(OVERSAMPLE / 2 + MajSpan);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  logic tick;

  uart_baud_tick #(
    .DIV (Div)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  uart_state_e      state_q;
  logic             rxd_meta_q, rxd_sync_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [1:0]       samp_q;
  logic             rx_ready_q;
  logic [7:0]       rx_data_q;
  logic             frame_err_q;
  logic             overrun_q;
`ifdef UART_RX_PARITY_EN
  logic             parity_bit_q;
  logic             parity_err_q;
  logic             parity_bad;
`endif

  logic bit_maj, at_hi, at_last, in_bit;

  always_comb begin
    // Only meaningful on the SampHi tick, when samp_q holds the two earlier samples.
    bit_maj = maj3(samp_q[1], samp_q[0], rxd_sync_q);
    at_hi   = tick && (tick_cnt_q == SampHi);
    at_last = tick && (tick_cnt_q == TickLast);
    in_bit  = (state_q != StIdle) && (state_q != StWaitHigh);
  end

`ifdef UART_RX_PARITY_EN
  assign parity_bad = ^{shift_q, parity_bit_q};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      samp_q       <= '0;
      rx_ready_q   <= 1'b0;
      rx_data_q    <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxd_meta_q  <= uart_rxd_i;
      rxd_sync_q  <= rxd_meta_q;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Byte completion below is written later, so it overrides a same-cycle clear.
      if (rx_clear_i) begin
        rx_ready_q <= 1'b0;
        overrun_q  <= 1'b0;
      end

      if (tick) begin
        if (in_bit) begin
          if (tick_cnt_q == SampLo || tick_cnt_q == SampMid) begin
            samp_q <= {samp_q[0], rxd_sync_q};
          end
          tick_cnt_q <= at_last ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
          StIdle: begin
            if (!rxd_sync_q) begin
              state_q    <= StStart;
              tick_cnt_q <= '0;
            end
          end
          StStart: begin
            if (at_hi && bit_maj) begin
              state_q <= StIdle;
            end else if (at_last) begin
              state_q   <= StData;
              bit_idx_q <= '0;
            end
          end
          StData: begin
            if (at_hi) begin
              shift_q <= {bit_maj, shift_q[7:1]};
            end
            if (at_last) begin
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          StParity: begin
            if (at_hi) begin
              parity_bit_q <= bit_maj;
            end
            if (at_last) begin
              state_q <= StStop;
            end
          end
`endif
          StStop: begin
            // Decide at the last stop sample rather than the bit end, so a start bit
            // following a short stop bit is never missed.
            if (at_hi) begin
              if (!bit_maj) begin
                frame_err_q <= 1'b1;
                state_q     <= StWaitHigh;
`ifdef UART_RX_PARITY_EN
              end else if (parity_bad) begin
                parity_err_q <= 1'b1;
                state_q      <= StIdle;
`endif
              end else begin
                rx_data_q  <= shift_q;
                rx_ready_q <= 1'b1;
                if (rx_ready_q) begin
                  overrun_q <= 1'b1;
                end
                state_q <= StIdle;
              end
            end
          end
          StWaitHigh: begin
            if (rxd_sync_q) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign rx_data_o   = rx_data_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 7.3728 MHz / 115200 baud / x16 (64 cycles per bit).
module tb_uart_rx_core;

  localparam int unsigned ClkFreq = 7_372_800;
  localparam int unsigned Baud    = 115200;
  localparam int unsigned Os      = 16;
  localparam int unsigned BitCyc  = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       clr;
  logic       rx_ready_o;
  logic [7:0] rx_data_o;
  logic       frame_err_o;
  logic       overrun_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int fe_cnt = 0;

  uart_rx_core #(
    .CLK_FREQ   (ClkFreq),
    .BAUD       (Baud),
    .OVERSAMPLE (Os)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .uart_rxd_i   (rxd),
    .rx_clear_i   (clr),
    .rx_ready_o   (rx_ready_o),
    .rx_data_o    (rx_data_o),
    .frame_err_o  (frame_err_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o (parity_err_o),
`endif
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  // Counts high cycles of frame_err_o, so a wide pulse shows up as an extra count.
  always @(posedge clk) begin
    if (frame_err_o !== 1'b0) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    idle(BitCyc);
  endtask

  // Start bit plus data bits (plus parity in the parity build); stop is left to the caller.
  task automatic send_head(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_head(d);
    drive_bit(stop);
    rxd = 1'b1;
    idle(16);
  endtask

  initial begin
    logic       seen;
    int         fe_before;
    logic [7:0] f0;

    rst = 1'b1;
    rxd = 1'b1;
    clr = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_ready", {31'd0, rx_ready_o}, 32'd0);
    check("rst_data", {24'd0, rx_data_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    check("rst_ovr", {31'd0, overrun_o}, 32'd0);
    idle(20);

    // Good frame 0xA5.
    send_byte(8'hA5, 1'b1);
    check("a5_ready", {31'd0, rx_ready_o}, 32'd1);
    check("a5_data", {24'd0, rx_data_o}, 32'hA5);
    check("a5_ferr_cnt", fe_cnt, 32'd0);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("a5_cleared", {31'd0, rx_ready_o}, 32'd0);

    // Bad stop bit on 0x3C, then a good 0x55.
    send_head(8'h3C);
    drive_bit(1'b0);
    rxd = 1'b1;
    idle(32);
    check("3c_ferr_one_cycle", fe_cnt, 32'd1);
    check("3c_no_ready", {31'd0, rx_ready_o}, 32'd0);
    check("3c_data_kept", {24'd0, rx_data_o}, 32'hA5);
    send_byte(8'h55, 1'b1);
    check("55_ready", {31'd0, rx_ready_o}, 32'd1);
    check("55_data", {24'd0, rx_data_o}, 32'h55);
    check("55_ferr_cnt", fe_cnt, 32'd1);

    // 20-cycle low glitch on the idle line.
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(3 * BitCyc);
    check("glitch_ready", {31'd0, rx_ready_o}, 32'd1);
    check("glitch_data", {24'd0, rx_data_o}, 32'h55);
    check("glitch_ferr_cnt", fe_cnt, 32'd1);
    check("glitch_ovr", {31'd0, overrun_o}, 32'd0);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;

    // Back-to-back 0x11, 0x22 without acknowledge.
    send_head(8'h11);
    drive_bit(1'b1);
    check("11_data", {24'd0, rx_data_o}, 32'h11);
    check("11_no_ovr", {31'd0, overrun_o}, 32'd0);
    send_byte(8'h22, 1'b1);
    check("22_data", {24'd0, rx_data_o}, 32'h22);
    check("22_ready", {31'd0, rx_ready_o}, 32'd1);
    check("22_ovr", {31'd0, overrun_o}, 32'd1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("ovr_clr_ready", {31'd0, rx_ready_o}, 32'd0);
    check("ovr_clr_ovr", {31'd0, overrun_o}, 32'd0);
    idle(5);
    check("ovr_stays_clear", {31'd0, overrun_o}, 32'd0);

    // Hold clear through the stop bit and drop it once ready is seen, so clear is high
    // in the completion cycle.
    send_head(8'h7E);
    rxd  = 1'b1;
    clr  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < BitCyc && !seen; i++) begin
      @(negedge clk);
      if (rx_ready_o === 1'b1) seen = 1'b1;
    end
    clr = 1'b0;
    check("7e_ready_seen", {31'd0, seen}, 32'd1);
    idle(BitCyc);
    check("7e_ready", {31'd0, rx_ready_o}, 32'd1);
    check("7e_data", {24'd0, rx_data_o}, 32'h7E);
    check("7e_no_ovr", {31'd0, overrun_o}, 32'd0);

    // One-cycle reset in the middle of bit 4 of 0xF0.
    fe_before = fe_cnt;
    f0 = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(f0[i]);
    rxd = f0[4];
    idle(BitCyc / 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mrst_ready", {31'd0, rx_ready_o}, 32'd0);
    check("mrst_data", {24'd0, rx_data_o}, 32'd0);
    check("mrst_ferr", {31'd0, frame_err_o}, 32'd0);
    check("mrst_ovr", {31'd0, overrun_o}, 32'd0);
    // Remaining high bits 5..7 and stop of the aborted frame.
    rxd = 1'b1;
    idle(BitCyc / 2 + 4 * BitCyc + 16);
    check("mrst_no_byte", {31'd0, rx_ready_o}, 32'd0);
    check("mrst_no_ferr", fe_cnt - fe_before, 32'd0);
    send_byte(8'h81, 1'b1);
    check("81_ready", {31'd0, rx_ready_o}, 32'd1);
    check("81_data", {24'd0, rx_data_o}, 32'h81);
    check("81_ovr", {31'd0, overrun_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
